// File: rtl/lane_event_sink.sv
// lane_event_sink: synchronises N async lanes and detects rising edges, then queues the
// round-robin-granted lane indices in a FIFO drained over valid/ready. Rev 1.0
`default_nettype none

module lane_event_sink #(
    parameter int N           = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int LW         = (N > 1) ? $clog2(N) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  lanes_i,
    output logic          evt_valid_o,
    input  logic          evt_ready_i,
    output logic [LW-1:0] evt_lane_o,
    output logic [CW-1:0] evt_count_o,
    output logic          ovf_o,
    input  logic          ovf_clr_i
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  prev_q;
    logic [N-1:0]  pending_q, pending_d;
    logic [LW-1:0] rr_ptr_q, rr_ptr_d;
    logic          ovf_q, ovf_d;
    logic [LW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [N-1:0]  sy;
    logic [N-1:0]  rise;
    logic [N-1:0]  grant_vec;
    logic [LW-1:0] grant_idx;
    logic [LW-1:0] scan_idx;
    logic          found;
    logic          push_ok;
    logic          push;
    logic          pop;
    int            idx;

    assign sy   = sync_q[SYNC_STAGES-1];
    assign rise = sy & ~prev_q;
    assign pop  = (count_q != '0) & evt_ready_i;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = (count_q < CW'(DEPTH)) | pop;

    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        scan_idx  = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            scan_idx = LW'(idx);
            if (!found && push_ok && pending_q[scan_idx]) begin
                found               = 1'b1;
                grant_idx           = scan_idx;
                grant_vec[scan_idx] = 1'b1;
            end
        end
    end

    assign push      = found;
    assign pending_d = (pending_q & ~grant_vec) | rise;
    assign rr_ptr_d  = !found ? rr_ptr_q :
                       (grant_idx == LW'(N - 1)) ? '0 : grant_idx + 1'b1;
    // Set has priority over a clear arriving in the same cycle.
    assign ovf_d     = (|(rise & pending_q & ~grant_vec)) | (ovf_q & ~ovf_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q    <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q[0] <= lanes_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q    <= sy;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign evt_valid_o = (count_q != '0);
    assign evt_lane_o  = mem_q[rd_ptr_q];
    assign evt_count_o = count_q;
    assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_event_sink.sv
// tb_lane_event_sink: random and directed stimulus against a queue-based reference model.
`default_nettype none

module tb_lane_event_sink;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int LW    = 2;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  lanes = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [LW-1:0] evt_lane;
    logic [CW-1:0] evt_count;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [N-1:0] dl [$];
    bit   [N-1:0] m_prev;
    bit   [N-1:0] m_pend;
    int           m_rr;
    int           m_count;
    bit           m_ovf;
    int           exp_q [$];

    lane_event_sink #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .lanes_i     (lanes),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_lane_o  (evt_lane),
        .evt_count_o (evt_count),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        dl.delete();
        for (int s = 0; s < SS; s++) dl.push_back('0);
        m_prev  = '0;
        m_pend  = '0;
        m_rr    = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the behaviour: edge detect, round-robin pick, FIFO bookkeeping.
    task automatic model_step();
        logic [N-1:0] sy;
        bit           do_pop;
        bit           set_ovf;
        bit           r;
        int           k;
        int           c;
        sy      = dl[SS-1];
        do_pop  = (m_count > 0) && evt_ready;
        k       = -1;
        set_ovf = 1'b0;
        if (m_count < DEPTH || do_pop) begin
            for (int j = 0; j < N; j++) begin
                c = (m_rr + j) % N;
                if (k < 0 && m_pend[c]) k = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            r = sy[i] && !m_prev[i];
            if (r && m_pend[i] && i != k) set_ovf = 1'b1;
            m_pend[i] = (m_pend[i] && i != k) || r;
        end
        if (k >= 0) begin
            exp_q.push_back(k);
            m_rr = (k + 1) % N;
            m_count++;
        end
        if (do_pop) m_count--;
        m_ovf  = set_ovf ? 1'b1 : (m_ovf && !ovf_clr);
        m_prev = sy;
        dl.push_front(lanes);
        void'(dl.pop_back());
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("count", int'(evt_count), m_count);
                check("valid", int'(evt_valid), int'(m_count != 0));
                check("ovf", int'(ovf), int'(m_ovf));
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL lane actual=%0d expected=<none> at %0t", evt_lane, $time);
                    end else begin
                        check("lane", int'(evt_lane), exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int cyc;
        #12;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_count", int'(evt_count), 0);
        check("rst_lane", int'(evt_lane), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cycles(4);

        // single edge latency
        lanes = 4'b0100;
        cyc = 0;
        while (!evt_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 4);
        check("single_lane", int'(evt_lane), 2);
        cycles(4);
        lanes = '0;
        cycles(4);

        // simultaneous rises, drained in rr order by the scoreboard
        lanes = 4'b1111;
        cycles(10);
        lanes = '0;
        cycles(4);

        // fill the FIFO, leave one pending, then merge a second edge into it
        evt_ready = 1'b0;
        lanes = 4'b1111;
        cycles(10);
        check("full_count", int'(evt_count), 4);
        lanes = '0;
        cycles(4);
        lanes = 4'b0001;
        cycles(6);
        check("full_ovf0", int'(ovf), 0);
        lanes = '0;
        cycles(4);
        lanes = 4'b0001;
        cycles(6);
        check("full_ovf1", int'(ovf), 1);
        evt_ready = 1'b1;
        cycles(12);
        check("drain_count", int'(evt_count), 0);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);
        lanes = '0;
        cycles(4);

        // random traffic with a mid-stream asynchronous reset
        for (int t = 0; t < 1500; t++) begin
            @(posedge clk);
            if (t == 700) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("arst_valid", int'(evt_valid), 0);
                check("arst_count", int'(evt_count), 0);
                check("arst_ovf", int'(ovf), 0);
                repeat (2) @(posedge clk);
                #3;
                rst_n = 1'b1;
            end else begin
                #1;
                for (int b = 0; b < N; b++) begin
                    if ($urandom_range(0, 5) == 0) lanes[b] = ~lanes[b];
                end
                evt_ready = ($urandom_range(0, 9) < 6);
                ovf_clr   = ($urandom_range(0, 15) == 0);
            end
        end

        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        cycles(40);
        check("drained", exp_q.size(), 0);
        check("final_count", int'(evt_count), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
